// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
// Data-memory port between the load/store unit and the data memory.
//
// Signals:
//   dmem_req    LSU -> mem   request is active
//   dmem_we     LSU -> mem   1 = write, 0 = read
//   dmem_addr   LSU -> mem   word-aligned byte address
//   dmem_be     LSU -> mem   byte enables (ignored by memory on reads)
//   dmem_wdata  LSU -> mem   lane-replicated store data
//   dmem_ready  mem -> LSU   request accepted/completed at this edge
//   dmem_rdata  mem -> LSU   read word, valid while dmem_ready is high
//
// Modports: master = load/store unit, slave = memory.
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_ready;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
// Load/store unit sitting after the ALU. Turns a load/store instruction into
// a single ready-handshaked data-memory access, stalls the core while the
// access is outstanding, and returns the aligned/extended load result.
// Misaligned or illegal accesses, and accesses the memory never answers
// within TIMEOUT_CYCLES, are reported with a one-cycle fault pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   mem_read     instruction is a load
//   mem_write    instruction is a store
//   funct3       size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr         byte address from the ALU
//   store_data   rs2 value for stores
//   lsu_stall    combinational pipeline freeze
//   load_valid   one-cycle pulse, load_data valid
//   load_data    extended load result (0 outside the valid pulse)
//   lsu_fault    one-cycle pulse on misaligned/illegal/timeout
//   dmem         data-memory port (master side)
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  lsu_stall,
    output logic                  load_valid,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  lsu_fault,
    lsu_mem_stage_if.master       dmem
);

    // Sized so that TIMEOUT_CYCLES-1 always fits, including TIMEOUT_CYCLES=1.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic                  load_valid_q, load_valid_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  fault_q, fault_d;

    logic                  request;
    logic                  legal_f3;
    logic                  misaligned;
    logic                  illegal;
    logic [3:0]            be_req;
    logic [DATA_WIDTH-1:0] wdata_req;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] rd_ext;

    // Request decode: legality, byte enables and lane-replicated store data.
    // Unsigned sizes (100/101) exist only for loads.
    always_comb begin
        request    = mem_read | mem_write;
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            3'b000: legal_f3 = 1'b1;
            3'b001: begin legal_f3 = 1'b1;       misaligned = addr[0];          end
            3'b010: begin legal_f3 = 1'b1;       misaligned = (addr[1:0] != 2'b00); end
            3'b100: legal_f3 = ~mem_write;
            3'b101: begin legal_f3 = ~mem_write; misaligned = addr[0];          end
            default: legal_f3 = 1'b0;
        endcase
        illegal = (mem_read & mem_write) | ~legal_f3 | misaligned;

        case (funct3[1:0])
            2'b00: begin
                be_req    = 4'b0001 << addr[1:0];
                wdata_req = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_req    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_req = {2{store_data[15:0]}};
            end
            default: begin
                be_req    = 4'b1111;
                wdata_req = store_data;
            end
        endcase
    end

    // Load extraction from the returned word, using the size and byte offset
    // captured when the request was accepted.
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = dmem.dmem_rdata[7:0];
            2'd1:    rd_byte = dmem.dmem_rdata[15:8];
            2'd2:    rd_byte = dmem.dmem_rdata[23:16];
            default: rd_byte = dmem.dmem_rdata[31:24];
        endcase
        rd_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = dmem.dmem_rdata;
        endcase
    end

    // Stall while an access is pending; DONE releases the core so the
    // instruction retires at the edge that returns to IDLE.
    assign lsu_stall = (state_q == BUSY) | ((state_q == IDLE) & request);

    // Next-state logic. Memory-port fields are only loaded when a legal
    // request is accepted, so they stay stable for the whole BUSY phase.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        daddr_d      = daddr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        f3_d         = f3_q;
        off_d        = off_q;
        load_valid_d = 1'b0;
        load_data_d  = '0;
        fault_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (request) begin
                    if (illegal) begin
                        fault_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        daddr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
                        be_d    = be_req;
                        wdata_d = wdata_req;
                        f3_d    = funct3;
                        off_d   = addr[1:0];
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dmem.dmem_ready) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!we_q) begin
                        load_valid_d = 1'b1;
                        load_data_d  = rd_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            daddr_q      <= '0;
            be_q         <= 4'b0000;
            wdata_q      <= '0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            daddr_q      <= daddr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            fault_q      <= fault_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = daddr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign load_valid      = load_valid_q;
    assign load_data       = load_data_q;
    assign lsu_fault       = fault_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
// Self-checking bench for lsu_mem_stage: directed accesses followed by
// randomized loads/stores with random wait states, checked against a
// behavioural model of the access rules. The bench plays the data memory.
// ---------------------------------------------------------------------------
module tb_lsu_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        lsu_stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        lsu_fault;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] last_load_data;

    lsu_mem_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem_if ();

    lsu_mem_stage #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .funct3(funct3),
        .addr(addr),
        .store_data(store_data),
        .lsu_stall(lsu_stall),
        .load_valid(load_valid),
        .load_data(load_data),
        .lsu_fault(lsu_fault),
        .dmem(dmem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference model: access rules in terms of sizes and byte offsets.
    function automatic int access_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        if (rd && wr) return 0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
        return (a % access_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n = access_size(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int n = access_size(f3);
        if (n == 1) return {24'd0, sd[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * (a % 4)));
        h = 16'(word >> (16 * ((a % 4) / 2)));
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return word;
        endcase
    endfunction

    // Runs one instruction through the LSU; the bench answers dmem_req after
    // 'waits' wait states and checks every observable against the model.
    task automatic applyStimulus(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rdata, input int waits);
        bit legal;
        int exp_req, exp_stall, exp_lv, exp_fault;
        int stall_cnt, req_cnt, lv_cnt, fault_cnt, cycles;
        bit done;
        legal     = model_legal(rd, wr, f3, a);
        exp_req   = legal ? ((waits + 1 < TIMEOUT) ? waits + 1 : TIMEOUT) : 0;
        exp_stall = 1 + exp_req;
        exp_lv    = (legal && rd && waits < TIMEOUT) ? 1 : 0;
        exp_fault = (!legal || waits >= TIMEOUT) ? 1 : 0;
        stall_cnt = 0; req_cnt = 0; lv_cnt = 0; fault_cnt = 0; cycles = 0; done = 0;
        last_load_data = 32'hxxxx_xxxx;

        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        dmem_if.dmem_ready = 1'b0;
        dmem_if.dmem_rdata = rdata;
        while (!done && cycles < 64) begin
            #1;
            if (lsu_stall) stall_cnt++;
            if (dmem_if.dmem_req) begin
                req_cnt++;
                checkOutput({tag, "_addr"}, dmem_if.dmem_addr, a & ~32'd3);
                checkOutput({tag, "_we"}, 32'(dmem_if.dmem_we), 32'(wr));
                checkOutput({tag, "_be"}, 32'(dmem_if.dmem_be), 32'(model_be(f3, a)));
                if (wr) checkOutput({tag, "_wdata"}, dmem_if.dmem_wdata, model_wdata(f3, sd));
                dmem_if.dmem_ready = (req_cnt > waits);
            end else begin
                dmem_if.dmem_ready = 1'b0;
            end
            if (load_valid) begin
                lv_cnt++;
                last_load_data = load_data;
                checkOutput({tag, "_ldata"}, load_data, model_load(f3, a, rdata));
            end
            if (lsu_fault) begin
                fault_cnt++;
                checkOutput({tag, "_fault_ldata"}, load_data, 32'd0);
            end
            if (!lsu_stall) done = 1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
        if (!done) checkOutput({tag, "_cycle_bound"}, 32'd0, 32'd1);

        mem_read = 1'b0; mem_write = 1'b0;
        dmem_if.dmem_ready = 1'b0;
        checkOutput({tag, "_stall_cycles"}, stall_cnt, exp_stall);
        checkOutput({tag, "_req_cycles"}, req_cnt, exp_req);
        checkOutput({tag, "_load_valid"}, lv_cnt, exp_lv);
        checkOutput({tag, "_fault"}, fault_cnt, exp_fault);

        // Pulses must last exactly one cycle.
        @(negedge clk);
        #1;
        checkOutput({tag, "_post"}, {28'd0, load_valid, lsu_fault, lsu_stall, dmem_if.dmem_req}, 32'd0);
    endtask

    initial begin
        int post_flags;
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = '0; store_data = '0;
        dmem_if.dmem_ready = 1'b0;
        dmem_if.dmem_rdata = '0;

        #1;
        checkOutput("reset_req", 32'(dmem_if.dmem_req), 32'd0);
        checkOutput("reset_we", 32'(dmem_if.dmem_we), 32'd0);
        checkOutput("reset_addr", dmem_if.dmem_addr, 32'd0);
        checkOutput("reset_be", 32'(dmem_if.dmem_be), 32'd0);
        checkOutput("reset_wdata", dmem_if.dmem_wdata, 32'd0);
        checkOutput("reset_flags", {29'd0, load_valid, lsu_fault, lsu_stall}, 32'd0);
        checkOutput("reset_ldata", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed accesses.
        applyStimulus("lbu", 1, 0, 3'b100, 32'h1003, 32'h0, 32'h80FF1234, 0);
        checkOutput("tp_lbu", last_load_data, 32'h0000_0080);
        applyStimulus("lb", 1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0);
        checkOutput("tp_lb", last_load_data, 32'hFFFF_FF80);
        applyStimulus("lh", 1, 0, 3'b001, 32'h1002, 32'h0, 32'h80FF1234, 0);
        checkOutput("tp_lh", last_load_data, 32'hFFFF_80FF);
        applyStimulus("lhu", 1, 0, 3'b101, 32'h1002, 32'h0, 32'h80FF1234, 0);
        checkOutput("tp_lhu", last_load_data, 32'h0000_80FF);
        applyStimulus("sh", 0, 1, 3'b001, 32'h2002, 32'hDEADBEEF, 32'h0, 0);
        applyStimulus("lw_misaligned", 1, 0, 3'b010, 32'h3001, 32'h0, 32'h12345678, 0);
        applyStimulus("rd_and_wr", 1, 1, 3'b010, 32'h3000, 32'h0, 32'h12345678, 0);
        applyStimulus("ld_f3_011", 1, 0, 3'b011, 32'h3000, 32'h0, 32'h12345678, 0);
        applyStimulus("sbu_illegal", 0, 1, 3'b100, 32'h3000, 32'h55, 32'h0, 0);
        applyStimulus("sw_timeout", 0, 1, 3'b010, 32'h4000, 32'hCAFEF00D, 32'h0, 100);
        applyStimulus("sw_wait3", 0, 1, 3'b010, 32'h4004, 32'h0BADF00D, 32'h0, 3);
        applyStimulus("sb_lane2", 0, 1, 3'b000, 32'h4006, 32'h000000A5, 32'h0, 1);

        // Reset in the middle of an outstanding load.
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h5000;
        dmem_if.dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy_req", 32'(dmem_if.dmem_req), 32'd1);
        rst = 1'b0;
        mem_read = 1'b0;
        #1;
        checkOutput("rst_async_req", 32'(dmem_if.dmem_req), 32'd0);
        checkOutput("rst_async_stall", 32'(lsu_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        post_flags = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (load_valid || lsu_fault || lsu_stall || dmem_if.dmem_req) post_flags++;
        end
        checkOutput("rst_after_quiet", post_flags, 0);
        applyStimulus("lw_after_rst", 1, 0, 3'b010, 32'h5000, 32'h0, 32'h13579BDF, 2);

        // Randomized accesses.
        for (int n = 0; n < 60; n++) begin
            int  kind;
            bit  rd, wr;
            int  waits;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 19);
            rd = (kind != 0) && (kind < 11);
            wr = (kind == 0) || (kind >= 11);
            if (kind == 0) rd = 1;
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(0, 2));
            if (rd && !wr && $urandom_range(0, 2) == 0) f3 = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd5;
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            waits = ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(0, 4);
            applyStimulus($sformatf("rnd%0d", n), rd, wr, f3, a, $urandom, $urandom, waits);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
